spike_delay_line: RTL and testbench

SPIKE_DELAY_LINE -- requirements
Module: spike_delay_line

---
 rtl/spike_delay_line.sv | 112 +++++++++++
 tb/tb_spike_delay_line.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spike_delay_line.sv
// Per-synapse programmable spike delay line with a serially loaded delay table.
// Optional build macro SPIKE_COUNT_EN adds a registered popcount output (spike_count).
module spike_delay_line #(
    parameter int M  = 24,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic [M-1:0]  spikes_in,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_delay,
    output logic          cfg_busy,
    output logic [M-1:0]  delayed_spikes,
    output logic          out_valid
`ifdef SPIKE_COUNT_EN
    ,
    output logic [$clog2(M+1)-1:0] spike_count
`endif
);

    localparam int H  = (1 << DW) - 1;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {RUN, LOAD} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [M-1:0][DW-1:0]    del;
    logic [M-1:0][H-1:0]     hist;
    logic [M-1:0][H-1:0]     next_hist;
    logic [M-1:0]            next_delayed;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        next_delayed = '0;
        next_hist    = '0;
        for (int i = 0; i < M; i++) begin
            next_hist[i] = (hist[i] << 1) | H'(spikes_in[i]);
            if (del[i] == '0)
                next_delayed[i] = spikes_in[i];
            else
                next_delayed[i] = hist[i][del[i] - DW'(1)];
        end
    end

`ifdef SPIKE_COUNT_EN
    localparam int CW = $clog2(M + 1);
    logic [CW-1:0] next_count;

    always_comb begin
        next_count = '0;
        for (int i = 0; i < M; i++)
            next_count = next_count + CW'(next_delayed[i]);
    end
`endif

    // NOTE: the delay table is reset like any other register, so an aborted load never leaves stale delays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            idx            <= '0;
            del            <= '0;
            hist           <= '0;
            delayed_spikes <= '0;
            out_valid      <= 1'b0;
            cfg_busy       <= 1'b0;
`ifdef SPIKE_COUNT_EN
            spike_count    <= '0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            out_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (cfg_start) begin
                        state          <= LOAD;
                        idx            <= '0;
                        hist           <= '0;
                        delayed_spikes <= '0;
                        cfg_busy       <= 1'b1;
`ifdef SPIKE_COUNT_EN
                        spike_count    <= '0;
`endif
                    end else if (step) begin
                        hist           <= next_hist;
                        delayed_spikes <= next_delayed;
                        out_valid      <= 1'b1;
`ifdef SPIKE_COUNT_EN
                        spike_count    <= next_count;
`endif
                    end
                end
                LOAD: begin
                    // step and cfg_start are deliberately ignored while loading
                    if (cfg_valid) begin
                        del[idx] <= cfg_delay;
                        if (idx == IW'(M - 1)) begin
                            state    <= RUN;
                            idx      <= '0;
                            cfg_busy <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_delay_line.sv
// Directed bench for spike_delay_line: expected delayed vectors are queued per step
// and popped on each out_valid pulse.
module tb_spike_delay_line;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic [23:0] spikes_in;
    logic        cfg_start;
    logic        cfg_valid;
    logic [1:0]  cfg_delay;
    logic        cfg_busy;
    logic [23:0] delayed_spikes;
    logic        out_valid;
`ifdef SPIKE_COUNT_EN
    logic [4:0]  spike_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    spike_delay_line #(.M(24), .DW(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .step           (step),
        .spikes_in      (spikes_in),
        .cfg_start      (cfg_start),
        .cfg_valid      (cfg_valid),
        .cfg_delay      (cfg_delay),
        .cfg_busy       (cfg_busy),
        .delayed_spikes (delayed_spikes),
        .out_valid      (out_valid)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count    (spike_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One accepted step; the expected delayed vector goes on the scoreboard first.
    task automatic do_step(input logic [23:0] sp, input logic [23:0] expv);
        logic [23:0] want;
        step      = 1'b1;
        spikes_in = sp;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        step      = 1'b0;
        spikes_in = '0;
        check("step_out_valid", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                want = exp_q.pop_front();
                check("delayed_spikes", {8'd0, delayed_spikes}, {8'd0, want});
`ifdef SPIKE_COUNT_EN
                check("spike_count", {27'd0, spike_count}, $countones(want));
`endif
            end
        end
    endtask

    // mode 0: del[0]=3, others 0; mode 1: del[i]=i%4. noise drives step/cfg_start during beats.
    task automatic load_table(input bit start, input int mode, input bit noise);
        int busy_cycles;
        busy_cycles = 0;
        if (start) begin
            cfg_start = 1'b1;
            @(posedge clk); #1;
            cfg_start = 1'b0;
        end
        for (int i = 0; i < 24; i++) begin
            if (cfg_busy) busy_cycles++;
            cfg_valid = 1'b1;
            cfg_delay = (mode == 0) ? ((i == 0) ? 2'd3 : 2'd0) : 2'(i % 4);
            step      = noise;
            cfg_start = noise;
            spikes_in = noise ? 24'hFFFFFF : 24'h0;
            @(posedge clk); #1;
            if (noise) check("load_out_valid_low", {31'd0, out_valid}, 32'd0);
        end
        cfg_valid = 1'b0;
        step      = 1'b0;
        cfg_start = 1'b0;
        spikes_in = '0;
        check("load_busy_cycles", busy_cycles, 32'd24);
        check("load_busy_done", {31'd0, cfg_busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        step      = 1'b0;
        spikes_in = '0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_delay = '0;
        #12;
        reset = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_cfg_busy", {31'd0, cfg_busy}, 32'd0);
        check("reset_delayed", {8'd0, delayed_spikes}, 32'd0);

        // All delays zero: straight pass-through with one cycle latency.
        do_step(24'h00000F, 24'h00000F);
        @(posedge clk); #1;
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("hold_delayed", {8'd0, delayed_spikes}, 32'h00000F);

        // del[0]=3: a single spike on bit 0 emerges three steps later.
        load_table(1'b1, 0, 1'b0);
        do_step(24'h000001, 24'h000000);
        do_step(24'h000000, 24'h000000);
        do_step(24'h000000, 24'h000000);
        do_step(24'h000000, 24'h000001);
        @(posedge clk); #1;
        check("hold_after_gap", {8'd0, delayed_spikes}, 32'h000001);

        // del[i]=i%4, back-to-back steps: each delay class appears on its own step.
        load_table(1'b1, 1, 1'b0);
        do_step(24'hFFFFFF, 24'h111111);
        do_step(24'h000000, 24'h222222);
        do_step(24'h000000, 24'h444444);
        do_step(24'h000000, 24'h888888);
        do_step(24'h000000, 24'h000000);

        // cfg_start beats a simultaneous step and clears history.
        do_step(24'hFFFFFF, 24'h111111);
        step      = 1'b1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        step      = 1'b0;
        cfg_start = 1'b0;
        check("collide_out_valid", {31'd0, out_valid}, 32'd0);
        check("collide_busy", {31'd0, cfg_busy}, 32'd1);
        check("collide_cleared", {8'd0, delayed_spikes}, 32'd0);
        load_table(1'b0, 1, 1'b1);
        do_step(24'h000000, 24'h000000);
        do_step(24'h000000, 24'h000000);
        do_step(24'h000000, 24'h000000);

        // Reset after 10 load beats abandons the load and zeroes all delays.
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1;
            cfg_delay = 2'd3;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        check("midload_busy", {31'd0, cfg_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, cfg_busy}, 32'd0);
        check("abort_delayed", {8'd0, delayed_spikes}, 32'd0);
        reset = 1'b0;
        // cfg_valid in RUN must not write the table.
        cfg_valid = 1'b1;
        cfg_delay = 2'd3;
        do_step(24'hABCDEF, 24'hABCDEF);
        do_step(24'h123456, 24'h123456);
        do_step(24'h000000, 24'h000000);
        do_step(24'h654321, 24'h654321);
        cfg_valid = 1'b0;

        // Popcount boundary values (checked inside do_step when the count port exists).
        do_step(24'h0000FF, 24'h0000FF);
        do_step(24'hFFFFFF, 24'hFFFFFF);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
